// File: rtl/vga_fb_write_arbiter_pkg.sv
// Shared definitions for the framebuffer write arbiter: FSM state encodings,
// default screen geometry and small elaboration-time helpers.
package vga_fb_write_arbiter_pkg;

  typedef enum logic [1:0] {
    FB_IDLE  = 2'd0,
    FB_PEND  = 2'd1,
    FB_CLEAR = 2'd2
  } fbState_t;

  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_ADDR_W     = 19;
  localparam int DEF_COLOR_W    = 3;
  localparam int DEF_FIFO_DEPTH = 4;

  // Number of pixels written by one full-screen fill.
  function automatic int pixelCount(input int hActive, input int vActive);
    return hActive * vActive;
  endfunction

  // Counter width able to hold every value 0..depth.
  function automatic int occupancyWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vga_fb_write_arbiter_if.sv
// Bus bundle between the execute stage / clear control and the arbiter,
// including the video memory write port it drives.
interface vga_fb_write_arbiter_if #(
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 3
);
  logic               iCpuWrReq;
  logic [ADDR_W-1:0]  iCpuAddr;
  logic [COLOR_W-1:0] iCpuColor;
  logic               oCpuBusy;
  logic               iClearStart;
  logic [COLOR_W-1:0] iClearColor;
  logic               oClearBusy;
  logic               oClearDone;
  logic               oMemWe;
  logic [ADDR_W-1:0]  oMemWrAddr;
  logic [COLOR_W-1:0] oMemWrData;

  modport master (
    output iCpuWrReq, iCpuAddr, iCpuColor, iClearStart, iClearColor,
    input  oCpuBusy, oClearBusy, oClearDone, oMemWe, oMemWrAddr, oMemWrData
  );

  modport slave (
    input  iCpuWrReq, iCpuAddr, iCpuColor, iClearStart, iClearColor,
    output oCpuBusy, oClearBusy, oClearDone, oMemWe, oMemWrAddr, oMemWrData
  );
endinterface

// File: rtl/vga_fb_write_arbiter_pixel_wr_fifo.sv
// Posted-write FIFO for CPU pixel writes. Pushes while full and pops while
// empty are ignored; read data is the current head entry.
module pixel_wr_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] rdData,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wrPtr_r;
  logic [PTR_W-1:0] rdPtr_r;
  logic [CNT_W-1:0] count_r;
  logic             full_s;
  logic             empty_s;
  logic             doPush_s;
  logic             doPop_s;

  // Occupancy flags and qualified push/pop strobes.
  always_comb begin
    full_s   = (count_r == CNT_W'(DEPTH));
    empty_s  = (count_r == '0);
    doPush_s = push && !full_s;
    doPop_s  = pop && !empty_s;
  end

  // Storage, pointers and occupancy; pointers wrap naturally (depth is a power of two).
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wrPtr_r <= '0;
      rdPtr_r <= '0;
      count_r <= '0;
    end else begin
      if (doPush_s) begin
        mem_r[wrPtr_r] <= wrData;
        wrPtr_r        <= wrPtr_r + PTR_W'(1);
      end
      if (doPop_s) begin
        rdPtr_r <= rdPtr_r + PTR_W'(1);
      end
      case ({doPush_s, doPop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdData = mem_r[rdPtr_r];
  assign full   = full_s;
  assign empty  = empty_s;
  assign count  = count_r;

endmodule

// File: rtl/vga_fb_write_arbiter.sv
// Single write port arbiter for the video memory: posted CPU pixel writes and
// a full-screen fill engine, with program order kept across a clear.
module vga_fb_write_arbiter
  import vga_fb_write_arbiter_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int COLOR_W    = DEF_COLOR_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic                   Clock,
  input logic                   Reset,
  vga_fb_write_arbiter_if.slave fb
);

  localparam int FIFO_W = ADDR_W + COLOR_W;
  localparam int CNT_W  = occupancyWidth(FIFO_DEPTH);
  localparam int PIXELS = pixelCount(H_ACTIVE, V_ACTIVE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

  fbState_t           state_r;
  logic [CNT_W-1:0]   preCount_r;
  logic [ADDR_W-1:0]  fillAddr_r;
  logic               lastFill_r;
  logic [COLOR_W-1:0] clearColor_r;
  logic               clearBusy_r;
  logic               clearDone_r;
  logic               memWe_r;
  logic [ADDR_W-1:0]  memWrAddr_r;
  logic [COLOR_W-1:0] memWrData_r;

  logic               fifoFull_s;
  logic               fifoEmpty_s;
  logic [CNT_W-1:0]   fifoCount_s;
  logic [FIFO_W-1:0]  fifoRdData_s;
  logic [ADDR_W-1:0]  fifoAddr_s;
  logic [COLOR_W-1:0] fifoColor_s;
  logic               pushAcc_s;
  logic               popAcc_s;
  logic [CNT_W-1:0]   occNext_s;

  pixel_wr_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clock  (Clock),
    .Reset  (Reset),
    .push   (pushAcc_s),
    .pop    (popAcc_s),
    .wrData ({fb.iCpuAddr, fb.iCpuColor}),
    .rdData (fifoRdData_s),
    .full   (fifoFull_s),
    .empty  (fifoEmpty_s),
    .count  (fifoCount_s)
  );

  // Push/pop qualification; the FIFO only drains outside the fill so queued writes land on top of it.
  always_comb begin
    pushAcc_s   = fb.iCpuWrReq && !fifoFull_s;
    popAcc_s    = 1'b0;
    fifoAddr_s  = fifoRdData_s[FIFO_W-1:COLOR_W];
    fifoColor_s = fifoRdData_s[COLOR_W-1:0];
    if (!fifoEmpty_s && ((state_r == FB_IDLE) || (state_r == FB_PEND))) begin
      popAcc_s = 1'b1;
    end else begin
      popAcc_s = 1'b0;
    end
    // Entries still queued after this edge: everything ahead of a clear started now.
    occNext_s = fifoCount_s + CNT_W'(pushAcc_s) - CNT_W'(popAcc_s);
  end

  // Arbiter FSM with registered write port and clear status.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r      <= FB_IDLE;
      preCount_r   <= '0;
      fillAddr_r   <= '0;
      lastFill_r   <= 1'b0;
      clearColor_r <= '0;
      clearBusy_r  <= 1'b0;
      clearDone_r  <= 1'b0;
      memWe_r      <= 1'b0;
      memWrAddr_r  <= '0;
      memWrData_r  <= '0;
    end else begin
      memWe_r     <= 1'b0;
      memWrAddr_r <= '0;
      memWrData_r <= '0;
      clearDone_r <= 1'b0;
      case (state_r)
        FB_IDLE: begin
          if (popAcc_s) begin
            memWe_r     <= 1'b1;
            memWrAddr_r <= fifoAddr_s;
            memWrData_r <= fifoColor_s;
          end
          if (fb.iClearStart) begin
            clearColor_r <= fb.iClearColor;
            clearBusy_r  <= 1'b1;
            fillAddr_r   <= '0;
            lastFill_r   <= 1'b0;
            preCount_r   <= occNext_s;
            state_r      <= (occNext_s == '0) ? FB_CLEAR : FB_PEND;
          end
        end
        FB_PEND: begin
          // PEND is only entered with entries queued, so a pop is always available here.
          if (popAcc_s) begin
            memWe_r     <= 1'b1;
            memWrAddr_r <= fifoAddr_s;
            memWrData_r <= fifoColor_s;
            preCount_r  <= preCount_r - CNT_W'(1);
            if (preCount_r == CNT_W'(1)) begin
              state_r <= FB_CLEAR;
            end
          end
        end
        FB_CLEAR: begin
          if (lastFill_r) begin
            state_r     <= FB_IDLE;
            clearDone_r <= 1'b1;
            clearBusy_r <= 1'b0;
            lastFill_r  <= 1'b0;
            fillAddr_r  <= '0;
            preCount_r  <= '0;
          end else begin
            memWe_r     <= 1'b1;
            memWrAddr_r <= fillAddr_r;
            memWrData_r <= clearColor_r;
            if (fillAddr_r == LAST_ADDR) begin
              lastFill_r <= 1'b1;
            end else begin
              fillAddr_r <= fillAddr_r + ADDR_W'(1);
            end
          end
        end
        default: begin
          state_r     <= FB_IDLE;
          clearBusy_r <= 1'b0;
          lastFill_r  <= 1'b0;
        end
      endcase
    end
  end

  assign fb.oCpuBusy   = fifoFull_s;
  assign fb.oClearBusy = clearBusy_r;
  assign fb.oClearDone = clearDone_r;
  assign fb.oMemWe     = memWe_r;
  assign fb.oMemWrAddr = memWrAddr_r;
  assign fb.oMemWrData = memWrData_r;

endmodule

// File: tb/tb_vga_fb_write_arbiter.sv
// Directed bench for vga_fb_write_arbiter on an 8x4 screen with a 4-deep FIFO.
module tb_vga_fb_write_arbiter;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  vga_fb_write_arbiter_if #(.ADDR_W(19), .COLOR_W(3)) fb ();

  vga_fb_write_arbiter #(
    .H_ACTIVE   (8),
    .V_ACTIVE   (4),
    .ADDR_W     (19),
    .COLOR_W    (3),
    .FIFO_DEPTH (4)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .fb    (fb)
  );

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t wlog[$];
  int  cyc      = 0;
  int  doneCnt  = 0;
  int  doneCyc  = 0;
  int  passCnt  = 0;
  int  totalCnt = 0;

  // Write-port monitor: log every write and every done pulse.
  always @(negedge Clock) begin
    if (!Reset) begin
      cyc = cyc + 1;
      if (fb.oMemWe === 1'b1) wlog.push_back('{int'(fb.oMemWrAddr), int'(fb.oMemWrData), cyc});
      if (fb.oClearDone === 1'b1) begin
        doneCnt = doneCnt + 1;
        doneCyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    fb.iCpuWrReq   = 1'b0;
    fb.iCpuAddr    = 19'd0;
    fb.iCpuColor   = 3'd0;
    fb.iClearStart = 1'b0;
    fb.iClearColor = 3'd0;
  endtask

  task automatic wait_done(output bit ok, output int busyLow);
    int d0;
    d0 = doneCnt;
    ok = 1'b0;
    busyLow = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clock);
      #1;
      if (doneCnt != d0) begin
        ok = 1'b1;
        break;
      end
      if (fb.oClearBusy !== 1'b1) busyLow++;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    totalCnt++; if (fb.oMemWe !== 1'b0) $display("FAIL reset_we: got %b want 0", fb.oMemWe); else passCnt++;
    totalCnt++; if (fb.oMemWrAddr !== 19'd0) $display("FAIL reset_addr: got %0d want 0", fb.oMemWrAddr); else passCnt++;
    totalCnt++; if (fb.oMemWrData !== 3'd0) $display("FAIL reset_data: got %0d want 0", fb.oMemWrData); else passCnt++;
    totalCnt++; if (fb.oClearBusy !== 1'b0) $display("FAIL reset_clrbusy: got %b want 0", fb.oClearBusy); else passCnt++;
    totalCnt++; if (fb.oClearDone !== 1'b0) $display("FAIL reset_clrdone: got %b want 0", fb.oClearDone); else passCnt++;
    totalCnt++; if (fb.oCpuBusy !== 1'b0) $display("FAIL reset_cpubusy: got %b want 0", fb.oCpuBusy); else passCnt++;
    Reset = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_single_write();
    wlog.delete();
    fb.iCpuWrReq = 1'b1; fb.iCpuAddr = 19'd5; fb.iCpuColor = 3'b101;
    step();
    fb.iCpuWrReq = 1'b0;
    @(negedge Clock);
    totalCnt++; if (fb.oMemWe !== 1'b0) $display("FAIL single_early: we=%b want 0", fb.oMemWe); else passCnt++;
    @(negedge Clock);
    totalCnt++; if (fb.oMemWe !== 1'b1) $display("FAIL single_we: we=%b want 1", fb.oMemWe); else passCnt++;
    totalCnt++; if (fb.oMemWrAddr !== 19'd5) $display("FAIL single_addr: got %0d want 5", fb.oMemWrAddr); else passCnt++;
    totalCnt++; if (fb.oMemWrData !== 3'b101) $display("FAIL single_data: got %0d want 5", fb.oMemWrData); else passCnt++;
    @(negedge Clock);
    totalCnt++; if (fb.oMemWe !== 1'b0) $display("FAIL single_after: we=%b want 0", fb.oMemWe); else passCnt++;
    repeat (2) step();
  endtask

  task automatic test_clear_idle();
    bit ok;
    int busyLow, d0, errs;
    wlog.delete();
    d0 = doneCnt;
    fb.iClearStart = 1'b1; fb.iClearColor = 3'b010;
    step();
    fb.iClearStart = 1'b0;
    totalCnt++; if (fb.oClearBusy !== 1'b1) $display("FAIL clr_busy_rise: got %b want 1", fb.oClearBusy); else passCnt++;
    wait_done(ok, busyLow);
    totalCnt++; if (!ok) $display("FAIL clr_done_seen: no done within bound"); else passCnt++;
    totalCnt++; if (busyLow != 0) $display("FAIL clr_busy_span: busy low %0d cycles want 0", busyLow); else passCnt++;
    totalCnt++; if (fb.oClearBusy !== 1'b0) $display("FAIL clr_busy_fall: got %b want 0", fb.oClearBusy); else passCnt++;
    errs = (wlog.size() == 32) ? 0 : 1;
    for (int i = 0; i < wlog.size() && i < 32; i++)
      if (wlog[i].addr != i || wlog[i].data != 2 || wlog[i].cyc != wlog[0].cyc + i) errs++;
    totalCnt++; if (errs != 0) $display("FAIL clr_fill: %0d bad of %0d writes, want 32 contiguous addr 0..31 data 2", errs, wlog.size()); else passCnt++;
    totalCnt++; if (wlog.size() != 32 || doneCyc != wlog[wlog.size()-1].cyc + 1)
      $display("FAIL clr_done_timing: done at %0d want one after last write", doneCyc); else passCnt++;
    repeat (5) step();
    totalCnt++; if (doneCnt != d0 + 1) $display("FAIL clr_done_count: got %0d want %0d", doneCnt - d0, 1); else passCnt++;
  endtask

  task automatic test_ordering();
    bit ok;
    int busyLow, errs;
    int expA[35];
    int expD[35];
    wlog.delete();
    expA[0] = 1; expA[1] = 2; expA[2] = 3;
    expD[0] = 1; expD[1] = 2; expD[2] = 3;
    for (int i = 0; i < 32; i++) begin
      expA[3+i] = i;
      expD[3+i] = 4;
    end
    fb.iCpuWrReq = 1'b1; fb.iCpuAddr = 19'd1; fb.iCpuColor = 3'd1;
    step();
    fb.iCpuAddr = 19'd2; fb.iCpuColor = 3'd2;
    step();
    fb.iCpuAddr = 19'd3; fb.iCpuColor = 3'd3;
    fb.iClearStart = 1'b1; fb.iClearColor = 3'd4;
    step();
    idle_inputs();
    wait_done(ok, busyLow);
    totalCnt++; if (!ok) $display("FAIL order_done_seen: no done within bound"); else passCnt++;
    errs = (wlog.size() == 35) ? 0 : 1;
    for (int i = 0; i < wlog.size() && i < 35; i++)
      if (wlog[i].addr != expA[i] || wlog[i].data != expD[i]) errs++;
    totalCnt++; if (errs != 0) $display("FAIL order_seq: %0d bad of %0d writes, want 1,2,3 then fill", errs, wlog.size()); else passCnt++;
    totalCnt++; if (wlog.size() != 35 || wlog[34].cyc - wlog[0].cyc != 34)
      $display("FAIL order_gapless: writes not on 35 consecutive cycles (n=%0d)", wlog.size()); else passCnt++;
    repeat (3) step();
  endtask

  task automatic test_writes_during_fill();
    bit ok;
    int busyLow, errs;
    wlog.delete();
    fb.iClearStart = 1'b1; fb.iClearColor = 3'd6;
    step();
    fb.iClearStart = 1'b0;
    for (int k = 0; k < 5; k++) begin
      fb.iCpuWrReq = 1'b1; fb.iCpuAddr = 19'(100 + k); fb.iCpuColor = 3'(k + 1);
      step();
      if (k == 2) begin
        totalCnt++; if (fb.oCpuBusy !== 1'b0) $display("FAIL fill_busy3: got %b want 0", fb.oCpuBusy); else passCnt++;
      end
      if (k == 3) begin
        totalCnt++; if (fb.oCpuBusy !== 1'b1) $display("FAIL fill_busy4: got %b want 1", fb.oCpuBusy); else passCnt++;
      end
    end
    fb.iCpuWrReq = 1'b0;
    wait_done(ok, busyLow);
    totalCnt++; if (!ok) $display("FAIL fill_done_seen: no done within bound"); else passCnt++;
    repeat (10) step();
    errs = (wlog.size() == 36) ? 0 : 1;
    for (int i = 0; i < wlog.size() && i < 36; i++) begin
      if (i < 32 && (wlog[i].addr != i || wlog[i].data != 6)) errs++;
      if (i >= 32 && (wlog[i].addr != 100 + i - 32 || wlog[i].data != i - 31)) errs++;
    end
    totalCnt++; if (errs != 0) $display("FAIL fill_queue: %0d bad of %0d writes, want fill then 100..103", errs, wlog.size()); else passCnt++;
    totalCnt++; if (wlog.size() != 36 || wlog[32].cyc <= doneCyc)
      $display("FAIL fill_after_done: first queued write not after done (done=%0d)", doneCyc); else passCnt++;
    totalCnt++; if (fb.oCpuBusy !== 1'b0) $display("FAIL fill_busy_end: got %b want 0", fb.oCpuBusy); else passCnt++;
  endtask

  task automatic test_reset_mid_fill();
    bit ok, found;
    int busyLow, d0, nAtReset, errs;
    wlog.delete();
    d0 = doneCnt;
    found = 1'b0;
    fb.iClearStart = 1'b1; fb.iClearColor = 3'd3;
    step();
    fb.iClearStart = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clock);
      if (fb.oMemWe === 1'b1 && fb.oMemWrAddr === 19'd10) begin
        found = 1'b1;
        break;
      end
    end
    totalCnt++; if (!found) $display("FAIL rst_reach10: fill address 10 never seen"); else passCnt++;
    #2;
    nAtReset = wlog.size();
    Reset = 1'b1;
    #1;
    totalCnt++; if (fb.oMemWe !== 1'b0 || fb.oMemWrAddr !== 19'd0 || fb.oMemWrData !== 3'd0)
      $display("FAIL rst_port_zero: we=%b addr=%0d data=%0d want 0", fb.oMemWe, fb.oMemWrAddr, fb.oMemWrData); else passCnt++;
    totalCnt++; if (fb.oClearBusy !== 1'b0) $display("FAIL rst_busy_zero: got %b want 0", fb.oClearBusy); else passCnt++;
    step();
    Reset = 1'b0;
    repeat (40) step();
    totalCnt++; if (doneCnt != d0) $display("FAIL rst_no_done: got %0d done pulses want 0", doneCnt - d0); else passCnt++;
    totalCnt++; if (wlog.size() != nAtReset) $display("FAIL rst_no_writes: got %0d writes want %0d", wlog.size(), nAtReset); else passCnt++;
    wlog.delete();
    fb.iClearStart = 1'b1; fb.iClearColor = 3'd1;
    step();
    fb.iClearStart = 1'b0;
    wait_done(ok, busyLow);
    errs = (ok && wlog.size() == 32) ? 0 : 1;
    for (int i = 0; i < wlog.size() && i < 32; i++)
      if (wlog[i].addr != i || wlog[i].data != 1) errs++;
    totalCnt++; if (errs != 0) $display("FAIL rst_restart: %0d bad of %0d writes, want addr 0..31 data 1", errs, wlog.size()); else passCnt++;
    repeat (3) step();
  endtask

  task automatic test_ignored_restart();
    bit ok;
    int busyLow, d0, errs;
    wlog.delete();
    d0 = doneCnt;
    fb.iClearStart = 1'b1; fb.iClearColor = 3'd2;
    step();
    fb.iClearStart = 1'b0;
    repeat (5) step();
    fb.iClearStart = 1'b1; fb.iClearColor = 3'b111;
    step();
    idle_inputs();
    wait_done(ok, busyLow);
    totalCnt++; if (!ok) $display("FAIL ign_done_seen: no done within bound"); else passCnt++;
    repeat (40) step();
    errs = (wlog.size() == 32) ? 0 : 1;
    for (int i = 0; i < wlog.size() && i < 32; i++)
      if (wlog[i].addr != i || wlog[i].data != 2) errs++;
    totalCnt++; if (errs != 0) $display("FAIL ign_fill: %0d bad of %0d writes, want addr 0..31 data 2", errs, wlog.size()); else passCnt++;
    totalCnt++; if (doneCnt != d0 + 1) $display("FAIL ign_single_done: got %0d want 1", doneCnt - d0); else passCnt++;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_write();
    test_clear_idle();
    test_ordering();
    test_writes_during_fill();
    test_reset_mid_fill();
    test_ignored_restart();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
